mfp_irq_ctrl: RTL and testbench



---
 rtl/mfp_irq_pkg.sv | 28 ++
 rtl/mfp_irq_prio.sv | 25 ++
 rtl/mfp_irq_ctrl.sv | 159 +++++++++++++++
 tb/tb_mfp_irq_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_irq_pkg.sv
// Shared constants for the MFP interrupt controller: register indices,
// timer channel numbers and the default spurious vector.
package mfp_irq_pkg;

  localparam int unsigned NUM_CH = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned DAT_W  = 8;

  // Register index map (ADDR)
  localparam logic [3:0] IERA = 4'd3;
  localparam logic [3:0] IERB = 4'd4;
  localparam logic [3:0] IPRA = 4'd5;
  localparam logic [3:0] IPRB = 4'd6;
  localparam logic [3:0] ISRA = 4'd7;
  localparam logic [3:0] ISRB = 4'd8;
  localparam logic [3:0] IMRA = 4'd9;
  localparam logic [3:0] IMRB = 4'd10;
  localparam logic [3:0] VR   = 4'd11;

  // Timer channel numbers on INT_SRC
  localparam int unsigned CH_TMR_A = 13;
  localparam int unsigned CH_TMR_B = 8;
  localparam int unsigned CH_TMR_C = 5;
  localparam int unsigned CH_TMR_D = 4;

  localparam logic [7:0] SPUR_VEC_DEF = 8'h18;

endpackage

// File: rtl/mfp_irq_prio.sv
// Highest-set-bit encoder over the 16 interrupt channels.
//   vec   : channel bit vector, bit 15 = highest priority
//   any_c : at least one bit set
//   idx_c : index of the highest set bit (0 when none set)
module mfp_irq_prio
  import mfp_irq_pkg::*;
(
  input  logic [NUM_CH-1:0] vec,
  output logic              any_c,
  output logic [IDX_W-1:0]  idx_c
);

  // Ascending scan: the last set bit seen is the highest
  always_comb begin
    any_c = 1'b0;
    idx_c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (vec[i]) begin
        any_c = 1'b1;
        idx_c = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mfp_irq_ctrl.sv
// MFP68901-style 16-channel interrupt controller.
//   CLK, RST_N         : clock, async active-low reset
//   SEL, WE, ADDR      : register access strobe, write enable, register index
//   DAT_I, DAT_O       : write data, registered read data
//   INT_SRC            : single-cycle event pulses, bit 15 highest priority
//   IRQ_N              : registered active-low interrupt request
//   IACK               : CPU acknowledge level
//   VEC_O, VEC_VALID   : acknowledged vector and its valid flag
module mfp_irq_ctrl
  import mfp_irq_pkg::*;
#(
  parameter logic [7:0] SPUR_VEC = SPUR_VEC_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              SEL,
  input  logic              WE,
  input  logic [3:0]        ADDR,
  input  logic [DAT_W-1:0]  DAT_I,
  output logic [DAT_W-1:0]  DAT_O,
  input  logic [NUM_CH-1:0] INT_SRC,
  output logic              IRQ_N,
  input  logic              IACK,
  output logic [DAT_W-1:0]  VEC_O,
  output logic              VEC_VALID
);

  logic [NUM_CH-1:0] ier, ipr, isr, imr;
  logic [3:0]        vr_base;
  logic              vr_s;

  logic [NUM_CH-1:0] ier_nxt, ipr_nxt, isr_nxt, imr_nxt;
  logic [3:0]        vr_base_nxt;
  logic              vr_s_nxt;
  logic [NUM_CH-1:0] ipr_keep, isr_keep;

  logic              iack_q;
  logic              iack_armed;

  logic              isr_any, win_any;
  logic [IDX_W-1:0]  isr_idx, win_idx;
  logic [NUM_CH-1:0] above, elig, ack_oh;
  logic              ack_edge, ack_hit;
  logic              wr, rd;
  logic [DAT_W-1:0]  rd_data;

  assign wr = SEL & WE;
  assign rd = SEL & ~WE;

  mfp_irq_prio u_prio_isr (
    .vec   (isr),
    .any_c (isr_any),
    .idx_c (isr_idx)
  );

  // Channels strictly above the highest in-service channel may interrupt
  always_comb begin
    above = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      above[i] = ~isr_any | (IDX_W'(i) > isr_idx);
    end
  end

  assign elig = ipr & imr & above;

  mfp_irq_prio u_prio_win (
    .vec   (elig),
    .any_c (win_any),
    .idx_c (win_idx)
  );

  // iack_armed blocks an acknowledge until IACK has been seen low after reset
  assign ack_edge = IACK & ~iack_q & iack_armed;
  assign ack_hit  = ack_edge & win_any;
  assign ack_oh   = ack_hit ? (NUM_CH'(1) << win_idx) : '0;

  // Register update: clears first, then event sets, then IER disable wins
  always_comb begin
    ier_nxt     = ier;
    imr_nxt     = imr;
    vr_base_nxt = vr_base;
    vr_s_nxt    = vr_s;
    ipr_keep    = '1;
    isr_keep    = '1;
    if (wr) begin
      case (ADDR)
        IERA: ier_nxt[15:8] = DAT_I;
        IERB: ier_nxt[7:0]  = DAT_I;
        IPRA: ipr_keep[15:8] = DAT_I;
        IPRB: ipr_keep[7:0]  = DAT_I;
        ISRA: isr_keep[15:8] = DAT_I;
        ISRB: isr_keep[7:0]  = DAT_I;
        IMRA: imr_nxt[15:8] = DAT_I;
        IMRB: imr_nxt[7:0]  = DAT_I;
        VR: begin
          vr_base_nxt = DAT_I[7:4];
          vr_s_nxt    = DAT_I[3];
          if (!DAT_I[3]) isr_keep = '0;
        end
        default: ;
      endcase
    end
    ipr_nxt = ((ipr & ipr_keep & ~ack_oh) | (INT_SRC & ier)) & ier_nxt;
    isr_nxt = (isr & isr_keep) | (vr_s ? ack_oh : '0);
  end

  // Read mux
  always_comb begin
    rd_data = '0;
    case (ADDR)
      IERA: rd_data = ier[15:8];
      IERB: rd_data = ier[7:0];
      IPRA: rd_data = ipr[15:8];
      IPRB: rd_data = ipr[7:0];
      ISRA: rd_data = isr[15:8];
      ISRB: rd_data = isr[7:0];
      IMRA: rd_data = imr[15:8];
      IMRB: rd_data = imr[7:0];
      VR:   rd_data = {vr_base, vr_s, 3'b000};
      default: rd_data = '0;
    endcase
  end

  // State, read data, IRQ and acknowledge registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ier        <= '0;
      ipr        <= '0;
      isr        <= '0;
      imr        <= '0;
      vr_base    <= '0;
      vr_s       <= 1'b0;
      DAT_O      <= '0;
      IRQ_N      <= 1'b1;
      iack_q     <= 1'b0;
      iack_armed <= 1'b0;
      VEC_O      <= '0;
      VEC_VALID  <= 1'b0;
    end else begin
      ier        <= ier_nxt;
      ipr        <= ipr_nxt;
      isr        <= isr_nxt;
      imr        <= imr_nxt;
      vr_base    <= vr_base_nxt;
      vr_s       <= vr_s_nxt;
      IRQ_N      <= ~win_any;
      iack_q     <= IACK;
      iack_armed <= iack_armed | ~IACK;
      if (rd) DAT_O <= rd_data;
      if (ack_edge) begin
        VEC_O     <= win_any ? {vr_base, win_idx} : SPUR_VEC;
        VEC_VALID <= 1'b1;
      end else if (!IACK) begin
        VEC_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mfp_irq_ctrl.sv
// Directed bench for mfp_irq_ctrl: a register access table plus
// hand-written interrupt and acknowledge sequences.
module tb_mfp_irq_ctrl;
  import mfp_irq_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        SEL, WE;
  logic [3:0]  ADDR;
  logic [7:0]  DAT_I, DAT_O;
  logic [15:0] INT_SRC;
  logic        IRQ_N, IACK;
  logic [7:0]  VEC_O;
  logic        VEC_VALID;

  int nvec = 0;
  int nerr = 0;

  mfp_irq_ctrl #(.SPUR_VEC(8'h18)) dut (
    .CLK(CLK), .RST_N(RST_N), .SEL(SEL), .WE(WE), .ADDR(ADDR),
    .DAT_I(DAT_I), .DAT_O(DAT_O), .INT_SRC(INT_SRC), .IRQ_N(IRQ_N),
    .IACK(IACK), .VEC_O(VEC_O), .VEC_VALID(VEC_VALID)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       do_wr;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic [3:0] raddr;
    logic [7:0] exp;
  } vec_t;

  vec_t vt [12];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    SEL = 1'b1; WE = 1'b1; ADDR = a; DAT_I = d;
    tick();
    SEL = 1'b0; WE = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    SEL = 1'b1; WE = 1'b0; ADDR = a;
    tick();
    SEL = 1'b0;
    d = DAT_O;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] d;
    rd(a, d);
    chk(name, d, exp);
  endtask

  task automatic pulse(input int ch);
    INT_SRC = 16'h0001 << ch;
    tick();
    INT_SRC = '0;
  endtask

  initial begin
    logic [7:0] d;
    RST_N = 1'b0; SEL = 1'b0; WE = 1'b0; ADDR = '0; DAT_I = '0;
    INT_SRC = '0; IACK = 1'b0;

    vt[0]  = '{1'b0, 4'd0, 8'h00, IERA,  8'h00};
    vt[1]  = '{1'b0, 4'd0, 8'h00, VR,    8'h00};
    vt[2]  = '{1'b1, IERA, 8'hA5, IERA,  8'hA5};
    vt[3]  = '{1'b1, IERB, 8'h3C, IERB,  8'h3C};
    vt[4]  = '{1'b1, IMRA, 8'h5A, IMRA,  8'h5A};
    vt[5]  = '{1'b1, IMRB, 8'hFF, IMRB,  8'hFF};
    vt[6]  = '{1'b1, VR,   8'h4F, VR,    8'h48};
    vt[7]  = '{1'b1, 4'd0, 8'hFF, 4'd0,  8'h00};
    vt[8]  = '{1'b1, 4'd15, 8'hFF, 4'd15, 8'h00};
    vt[9]  = '{1'b0, 4'd0, 8'h00, IPRA,  8'h00};
    vt[10] = '{1'b1, ISRA, 8'hFF, ISRA,  8'h00};
    vt[11] = '{1'b1, IERA, 8'h00, IERA,  8'h00};

    tick(); tick();
    RST_N = 1'b1;
    tick();

    // Reset state of outputs
    chk("rst_irq_n", {7'd0, IRQ_N}, 8'h01);
    chk("rst_vec_valid", {7'd0, VEC_VALID}, 8'h00);
    chk("rst_vec_o", VEC_O, 8'h00);
    chk("rst_dat_o", DAT_O, 8'h00);

    // Register access table
    for (int i = 0; i < 12; i++) begin
      if (vt[i].do_wr) wr(vt[i].waddr, vt[i].wdata);
      rd(vt[i].raddr, d);
      chk($sformatf("tbl%0d", i), d, vt[i].exp);
    end
    wr(IERB, 8'h00); wr(IMRA, 8'h00); wr(IMRB, 8'h00); wr(VR, 8'h00);

    // Timer A: pend, IRQ latency, acknowledge with S = 0
    wr(IERA, 8'h20); wr(IMRA, 8'h20); wr(VR, 8'h40);
    pulse(CH_TMR_A);
    chk("tA_irq_1cyc", {7'd0, IRQ_N}, 8'h01);
    tick();
    chk("tA_irq_2cyc", {7'd0, IRQ_N}, 8'h00);
    rd_chk("tA_ipra", IPRA, 8'h20);
    IACK = 1'b1;
    tick();
    chk("tA_vec", VEC_O, 8'h4D);
    chk("tA_valid", {7'd0, VEC_VALID}, 8'h01);
    rd_chk("tA_ipra_clr", IPRA, 8'h00);
    rd_chk("tA_isra", ISRA, 8'h00);
    chk("tA_irq_hi", {7'd0, IRQ_N}, 8'h01);
    chk("tA_valid_held", {7'd0, VEC_VALID}, 8'h01);
    IACK = 1'b0;
    tick();
    chk("tA_valid_drop", {7'd0, VEC_VALID}, 8'h00);
    chk("tA_vec_hold", VEC_O, 8'h4D);

    // In-service nesting with S = 1
    wr(VR, 8'h48); wr(IERB, 8'h10); wr(IMRB, 8'h10);
    pulse(CH_TMR_D);
    tick();
    chk("s1_irq4", {7'd0, IRQ_N}, 8'h00);
    IACK = 1'b1; tick();
    chk("s1_vec4", VEC_O, 8'h44);
    IACK = 1'b0; tick();
    rd_chk("s1_isrb", ISRB, 8'h10);
    rd_chk("s1_iprb", IPRB, 8'h00);
    chk("s1_irq_hi", {7'd0, IRQ_N}, 8'h01);
    pulse(CH_TMR_A);
    tick();
    chk("s1_irq13", {7'd0, IRQ_N}, 8'h00);
    IACK = 1'b1; tick();
    chk("s1_vec13", VEC_O, 8'h4D);
    IACK = 1'b0; tick();
    pulse(CH_TMR_D);
    tick(); tick();
    chk("s1_irq4_blocked", {7'd0, IRQ_N}, 8'h01);
    rd_chk("s1_isra", ISRA, 8'h20);
    wr(ISRA, 8'hDF);
    tick();
    chk("s1_irq4_below_isr", {7'd0, IRQ_N}, 8'h01);
    wr(ISRB, 8'hEF);
    chk("s1_irq_wr_edge", {7'd0, IRQ_N}, 8'h01);
    tick();
    chk("s1_irq4_released", {7'd0, IRQ_N}, 8'h00);
    rd_chk("s1_isrb_clr", ISRB, 8'h00);
    wr(IPRB, 8'h00); wr(VR, 8'h40);
    tick();

    // Spurious acknowledge
    chk("sp_irq_hi", {7'd0, IRQ_N}, 8'h01);
    IACK = 1'b1; tick();
    chk("sp_vec", VEC_O, 8'h18);
    chk("sp_valid", {7'd0, VEC_VALID}, 8'h01);
    IACK = 1'b0; tick();
    rd_chk("sp_iprb", IPRB, 8'h00);
    rd_chk("sp_isrb", ISRB, 8'h00);
    rd_chk("sp_vr", VR, 8'h40);
    rd_chk("sp_iera", IERA, 8'h20);

    // Set beats write-clear; disable beats set
    wr(IERA, 8'h01); wr(IMRA, 8'h01);
    SEL = 1'b1; WE = 1'b1; ADDR = IPRA; DAT_I = 8'h00; INT_SRC = 16'h0100;
    tick();
    SEL = 1'b0; WE = 1'b0; INT_SRC = '0;
    rd_chk("sb_ipra", IPRA, 8'h01);
    chk("sb_irq_lo", {7'd0, IRQ_N}, 8'h00);
    wr(IERA, 8'h00);
    rd_chk("dis_ipra", IPRA, 8'h00);
    chk("dis_irq_hi", {7'd0, IRQ_N}, 8'h01);
    wr(IERA, 8'h01);
    SEL = 1'b1; WE = 1'b1; ADDR = IERA; DAT_I = 8'h00; INT_SRC = 16'h0100;
    tick();
    SEL = 1'b0; WE = 1'b0; INT_SRC = '0;
    rd_chk("dis_vs_set", IPRA, 8'h00);

    // Masking retains pending, unmask raises IRQ one cycle later
    wr(IMRA, 8'h00); wr(IMRB, 8'h00);
    pulse(CH_TMR_D);
    tick(); tick();
    chk("msk_irq_hi", {7'd0, IRQ_N}, 8'h01);
    rd_chk("msk_iprb", IPRB, 8'h10);
    wr(IMRB, 8'h10);
    chk("unmsk_irq_edge", {7'd0, IRQ_N}, 8'h01);
    tick();
    chk("unmsk_irq_lo", {7'd0, IRQ_N}, 8'h00);

    // Reset in the middle of a handshake
    IACK = 1'b1; tick();
    chk("rh_vec", VEC_O, 8'h44);
    chk("rh_valid", {7'd0, VEC_VALID}, 8'h01);
    RST_N = 1'b0;
    #1;
    chk("rh_rst_valid", {7'd0, VEC_VALID}, 8'h00);
    chk("rh_rst_vec", VEC_O, 8'h00);
    chk("rh_rst_irq", {7'd0, IRQ_N}, 8'h01);
    chk("rh_rst_dat", DAT_O, 8'h00);
    tick();
    RST_N = 1'b1;
    tick();
    wr(IERB, 8'h10); wr(IMRB, 8'h10); wr(VR, 8'h40);
    pulse(CH_TMR_D);
    tick(); tick();
    chk("rh_no_ack_valid", {7'd0, VEC_VALID}, 8'h00);
    chk("rh_no_ack_vec", VEC_O, 8'h00);
    IACK = 1'b0; tick();
    IACK = 1'b1; tick();
    chk("rh_reack_vec", VEC_O, 8'h44);
    chk("rh_reack_valid", {7'd0, VEC_VALID}, 8'h01);
    IACK = 1'b0; tick();
    chk("rh_final_valid", {7'd0, VEC_VALID}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
